// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready selector with a single output register.
// A round-robin or fixed-priority arbiter picks one requesting channel, and
// its word is captured into the output register. A saturating counter
// tracks how many words the consumer has taken.
//
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   mode            0 = round-robin, 1 = fixed priority (lowest index wins)
//   in_valid/ready  per-channel handshake; in_ready is one-hot or zero
//   in_data         channel i at bits [i*WIDTH +: WIDTH]
//   out_valid/ready output handshake; out_data/out_ch come from the register
//   xfer_cnt        saturating count of output transfers
module rr_arb_mux #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH),
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic [N_CH-1:0]         in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        xfer_cnt
);

  logic [N_CH-1:0][WIDTH-1:0] in_word;
  assign in_word = in_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic             load_en, take, out_xfer;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W:0]   scan;
  logic [SEL_W-1:0] cand;

  assign load_en  = !out_valid_q | out_ready;
  assign out_xfer = out_valid_q & out_ready;

  // Arbiter: scan candidates in priority order, first requester wins.
  // Round-robin starts at ptr and wraps modulo N_CH (N_CH need not be a
  // power of two, so the wrap is an explicit subtract).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    cand    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (mode) begin
        cand = SEL_W'(k);
      end else begin
        scan = {1'b0, ptr_q} + (SEL_W+1)'(k);
        if (scan >= (SEL_W+1)'(N_CH)) scan = scan - (SEL_W+1)'(N_CH);
        cand = scan[SEL_W-1:0];
      end
      if (!gnt_vld && in_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // rst_n gates in_ready so no producer sees an accept while reset is held
  // (the register is empty then, so load_en alone would be 1).
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++)
      in_ready[i] = rst_n & load_en & gnt_vld & (gnt_idx == SEL_W'(i));
  end

  assign take = |in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = in_word[gnt_idx];
      out_ch_d    = gnt_idx;
      if (!mode)
        ptr_d = (gnt_idx == SEL_W'(N_CH-1)) ? '0 : gnt_idx + SEL_W'(1);
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    if (out_xfer && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed vectors with hand-computed expectations
// plus a per-cycle comparison against a behavioural model. A second
// instance with CNT_W=4 shares the inputs to exercise counter saturation.
module tb_rr_arb_mux;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic [N-1:0] in_valid;
  logic [N*W-1:0] in_data;
  logic         out_ready;

  logic [N-1:0] in_ready,  in_ready4;
  logic         out_valid, out_valid4;
  logic [W-1:0] out_data,  out_data4;
  logic [1:0]   out_ch,    out_ch4;
  logic [15:0]  xfer_cnt;
  logic [3:0]   xfer_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.N_CH(N), .WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt));

  rr_arb_mux #(.N_CH(N), .WIDTH(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4), .out_ch(out_ch4),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_valid = 0, m_data = 0, m_ch = 0, m_ptr = 0, m_cnt = 0, m_cnt4 = 0;

  // Which channel should win right now; -1 if nobody requests.
  function automatic int winner(input logic md, input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int c;
      c = md ? k : (ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] r;
    r = '0;
    g = winner(mode, in_valid, m_ptr);
    if (rst_n && g >= 0 && (m_valid == 0 || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      int g;
      bit xfer;
      g = winner(mode, in_valid, m_ptr);
      xfer = (m_valid != 0) && out_ready;
      if (xfer) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (g >= 0 && (m_valid == 0 || out_ready)) begin
        m_valid = 1;
        m_data = int'(in_data[g*W +: W]);
        m_ch = g;
        if (!mode) m_ptr = (g + 1) % N;
      end else if (xfer) begin
        m_valid = 0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("m_out_valid", 32'(out_valid), 32'(m_valid));
    chk("m_out_data",  32'(out_data),  32'(m_data));
    chk("m_out_ch",    32'(out_ch),    32'(m_ch));
    chk("m_in_ready",  32'(in_ready),  32'(exp_ready()));
    chk("m_xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
    chk("m_xfer_cnt4", 32'(xfer_cnt4), 32'(m_cnt4));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int ch, input int data);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_ch"},    32'(out_ch),    32'(ch));
    chk({name, "_data"},  32'(out_data),  32'(data));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; out_ready = 1'b1;
    in_valid = 4'b1111; in_data = 32'h33221100;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
    rst_n = 1'b1;

    // 1: round-robin over all channels
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("t1", i % 4, (i % 4) * 'h11);
    end
    chk("t1_cnt", 32'(xfer_cnt), 32'd4);

    // 2: fixed priority, ch0 always wins, then ch1 once ch0 drops
    mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("t2", 0, 'h00);
    end
    in_valid = 4'b1110;
    tick();
    expect_out("t2_drop", 1, 'h11);

    // 3: backpressure (ptr is 1 here, fixed mode left it alone)
    mode = 1'b0; in_data = 32'h33A51100; in_valid = 4'b0100;
    tick();
    expect_out("t3_load", 2, 'hA5);
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("t3_stall", 2, 'hA5);
      chk("t3_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_release_ready", 32'(in_ready), 32'b1000);
    tick();
    expect_out("t3_next", 3, 'h33);

    // 4: sparse round-robin from ptr=2 (ptr is 0 now; grant ch1 first)
    in_valid = 4'b0010;
    tick();
    expect_out("t4_prep", 1, 'h11);
    in_valid = 4'b1010;
    tick(); expect_out("t4_a", 3, 'h33);
    tick(); expect_out("t4_b", 1, 'h11);
    tick(); expect_out("t4_c", 3, 'h33);

    // 5: async reset with a word held and requests pending
    out_ready = 1'b0; in_valid = 4'b1111;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid",   32'(out_valid), 32'd0);
    chk("t5_data",    32'(out_data),  32'd0);
    chk("t5_cnt",     32'(xfer_cnt),  32'd0);
    chk("t5_cnt4",    32'(xfer_cnt4), 32'd0);
    chk("t5_inready", 32'(in_ready),  32'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    expect_out("t5_first", 0, 'h00);

    // 6: stream 20 transfers; the 4-bit counter must stick at 15
    for (int i = 0; i < 20; i++) tick();
    chk("t6_cnt16", 32'(xfer_cnt),  32'd20);
    chk("t6_cnt4",  32'(xfer_cnt4), 32'd15);

    // Mixed pattern: random requests, backpressure and mode flips
    for (int i = 0; i < 60; i++) begin
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      mode      = (i % 13) > 8;
      in_data   = $urandom;
      tick();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
